// File: rtl/switch_irq_pio_if.sv
// Memory-mapped slave bus for the switch/LED PIO: word address, one-cycle
// read and write strobes, 32-bit data in both directions.
interface switch_irq_pio_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/switch_irq_pio.sv
// Debounced switch input port with LED output register and edge-capture
// interrupt. Raw pins are synchronized, debounced per channel, and accepted
// transitions can latch into EDGE_CAP, which drives a masked, registered irq.
module switch_irq_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  switch_irq_pio_if.slave   avs,
  input  logic [WIDTH-1:0]  switches_export,
  output logic [WIDTH-1:0]  leds_export,
  output logic              irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_word;
  logic [31:0]      readdata_q;

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata;

  assign wdata            = avs.avs_writedata[WIDTH-1:0];
  assign leds_export      = data_out;
  assign avs.avs_readdata = readdata_q;

  // Two-flop synchronizer in front of everything else for the async pins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= switches_export;
      sync_q    <= sync_meta;
    end
  end

  // A channel flips once its synchronized value has disagreed with stable long enough.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync_q[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Per-channel debounce counters restart on any agreement or on acceptance.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      stable <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync_q[i] == stable[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      stable <= stable ^ accept;
    end
  end

  // Capture requests from accepted edges and write-1-to-clear requests from the bus.
  always_comb begin
    cap_set = (accept & sync_q & rise_en) | (accept & ~sync_q & fall_en);
    cap_clr = '0;
    if (avs.avs_write && (avs.avs_address == ADDR_EDGE_CAP)) begin
      cap_clr = wdata;
    end
  end

  // Control registers, edge capture (set beats clear) and the registered interrupt.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_out <= '0;
      irq_mask <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      if (avs.avs_write) begin
        case (avs.avs_address)
          ADDR_DATA_OUT: data_out <= wdata;
          ADDR_IRQ_MASK: irq_mask <= wdata;
          ADDR_RISE_EN:  rise_en  <= wdata;
          ADDR_FALL_EN:  fall_en  <= wdata;
          default:       ;
        endcase
      end
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  // Read mux over the current register contents, zero-extended to 32 bits.
  always_comb begin
    rd_word = '0;
    case (avs.avs_address)
      ADDR_DATA_IN:  rd_word[WIDTH-1:0] = stable;
      ADDR_DATA_OUT: rd_word[WIDTH-1:0] = data_out;
      ADDR_IRQ_MASK: rd_word[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_word[WIDTH-1:0] = edge_cap;
      ADDR_RISE_EN:  rd_word[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN:  rd_word[WIDTH-1:0] = fall_en;
      default:       rd_word = '0;
    endcase
  end

  // Read data registers on the strobe and holds until the next read.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      readdata_q <= '0;
    end else if (avs.avs_read) begin
      readdata_q <= rd_word;
    end
  end

endmodule

// File: tb/tb_switch_irq_pio.sv
// Self-checking bench for switch_irq_pio: directed scenarios followed by
// random bus traffic and switch activity, checked against a pin-history
// reference model through a read-data scoreboard plus per-cycle irq/LED checks.
module tb_switch_irq_pio;
  localparam int WIDTH = 4;
  localparam int DEB   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIDTH-1:0] sw = '0;
  logic [WIDTH-1:0] leds;
  logic             irq;

  int tests = 0;
  int fails = 0;

  switch_irq_pio_if bus();

  switch_irq_pio #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .avs             (bus),
    .switches_export (sw),
    .leds_export     (leds),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] m_stable, m_data_out, m_mask, m_cap, m_rise, m_fall;
  logic [WIDTH-1:0] m_acc, m_set, m_clr;
  logic             m_irq, m_irq_next, m_rd_valid, m_all_diff;
  logic [31:0]      exp_q[$];
  logic [WIDTH-1:0] hist[$];

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_stable);
      3'd1:    return 32'(m_data_out);
      3'd2:    return 32'(m_mask);
      3'd3:    return 32'(m_cap);
      3'd4:    return 32'(m_rise);
      3'd5:    return 32'(m_fall);
      default: return 32'd0;
    endcase
  endfunction

  // Model: a channel is accepted once its last DEB synchronized samples (pins two edges old) all differ from stable
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stable   = '0;
      m_data_out = '0;
      m_mask     = '0;
      m_cap      = '0;
      m_rise     = '0;
      m_fall     = '0;
      m_irq      = 1'b0;
      m_rd_valid = 1'b0;
      exp_q.delete();
      hist.delete();
      for (int k = 0; k < DEB + 2; k++) hist.push_back('0);
    end else begin
      m_irq_next = |(m_cap & m_mask);
      m_rd_valid = bus.avs_read;
      if (bus.avs_read) exp_q.push_back(model_reg(bus.avs_address));
      hist.push_front(sw);
      void'(hist.pop_back());
      for (int ch = 0; ch < WIDTH; ch++) begin
        m_all_diff = 1'b1;
        for (int k = 2; k < DEB + 2; k++) begin
          if (hist[k][ch] == m_stable[ch]) m_all_diff = 1'b0;
        end
        m_acc[ch] = m_all_diff;
      end
      m_set = (m_acc & ~m_stable & m_rise) | (m_acc & m_stable & m_fall);
      m_clr = '0;
      if (bus.avs_write) begin
        case (bus.avs_address)
          3'd1: m_data_out = bus.avs_writedata[WIDTH-1:0];
          3'd2: m_mask     = bus.avs_writedata[WIDTH-1:0];
          3'd3: m_clr      = bus.avs_writedata[WIDTH-1:0];
          3'd4: m_rise     = bus.avs_writedata[WIDTH-1:0];
          3'd5: m_fall     = bus.avs_writedata[WIDTH-1:0];
          default: ;
        endcase
      end
      m_cap    = (m_cap & ~m_clr) | m_set;
      m_stable = m_stable ^ m_acc;
      m_irq    = m_irq_next;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: irq and LEDs every cycle, read data whenever a read was issued on the last edge
  always @(negedge clk) begin
    check_output("irq", 32'(irq), 32'(m_irq));
    check_output("leds", 32'(leds), 32'(m_data_out));
    if (!rst_n) check_output("readdata_reset", bus.avs_readdata, 32'd0);
    if (m_rd_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL scoreboard_empty at %0t: got read, expected none queued", $time);
      end else begin
        check_output("readdata", bus.avs_readdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      int op;
      if ($urandom_range(0, 9) == 0) sw[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
      op = $urandom_range(0, 9);
      bus.avs_address   = 3'($urandom_range(0, 7));
      bus.avs_writedata = $urandom;
      bus.avs_read      = (op < 3);
      bus.avs_write     = (op >= 2) && (op < 5);
      @(negedge clk);
    end
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
  endtask

  initial begin
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset values of every register
    for (int a = 0; a < 6; a++) bus_read(3'(a));

    // Rising edge on channel 0 with interrupt enabled
    bus_write(3'd4, 32'h1);
    bus_write(3'd2, 32'h1);
    sw = 4'h1;
    idle(12);
    bus_read(3'd0);
    bus_read(3'd3);

    // Short glitch on channel 2 is rejected
    sw[2] = 1'b1;
    idle(5);
    sw[2] = 1'b0;
    idle(12);
    bus_read(3'd0);
    bus_read(3'd3);

    // Build EDGE_CAP=0x5 and clear it bit by bit
    bus_write(3'd4, 32'h5);
    sw[2] = 1'b1;
    idle(12);
    bus_read(3'd3);
    bus_write(3'd3, 32'h4);
    bus_read(3'd3);
    idle(2);
    bus_write(3'd3, 32'h1);
    idle(2);
    bus_read(3'd3);

    // Clear of bit 0 on the very edge a new rise on channel 0 is accepted
    sw[0] = 1'b0;
    idle(12);
    sw[0] = 1'b1;
    idle(9);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3);

    // LED register, unmapped and read-only addresses
    bus_write(3'd1, 32'hFFFF_FFFA);
    bus_read(3'd1);
    bus_read(3'd7);
    bus_write(3'd7, 32'hF);
    bus_write(3'd0, 32'hF);
    bus_read(3'd0);
    bus_read(3'd6);

    // Simultaneous read and write of IRQ_MASK returns the old value
    bus.avs_address   = 3'd2;
    bus.avs_writedata = 32'hE;
    bus.avs_read      = 1'b1;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus_read(3'd2);

    // Reset in the middle of a falling debounce with all fall enables set
    bus_write(3'd5, 32'hF);
    sw = 4'hF;
    idle(12);
    sw = 4'h0;
    idle(4);
    pulse_reset();
    idle(12);
    for (int a = 0; a < 6; a++) bus_read(3'(a));

    // Randomized traffic
    bus_write(3'd4, $urandom);
    bus_write(3'd5, $urandom);
    bus_write(3'd2, $urandom);
    apply_stimulus(1500);
    idle(2);
    pulse_reset();
    apply_stimulus(500);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
